// File: rtl/rv32i_pkg.sv
// Shared RV32I widths, the canonical NOP and the fetch-queue entry layout.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_queue.sv
// Circular queue of fetched {pc, instr} entries; flush empties it in a single edge.
module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetch_entry_t            wr_entry,
    output fetch_entry_t            head_entry,
    output logic [$clog2(QDEPTH):0] count
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  mem_q [QDEPTH];
    fetch_entry_t  mem_d [QDEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap for free because QDEPTH is restricted to powers of two.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = wr_entry;
                tail_d        = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect flush and a small fetch queue.
// Define IMEM_FETCH_MISALIGN_CHECK_EN to halt fetch on a misaligned redirect target.
module imem_fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            misalign_err
);

    localparam int unsigned   CW   = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   count;
    logic            halted;
    logic            push;
    logic            pop;
    logic            q_pop;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head_entry;

    // Redirect outranks both pop and push; the queue sees it as a flush.
    always_comb begin
        pop      = out_valid & out_ready;
        push     = fetch_en & ~redirect_valid & ~halted & ((count < FULL) | pop);
        q_pop    = pop & ~redirect_valid;
        wr_entry = '{pc: pc_q, instr: imem_instr};
        pc_d     = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(3);
        end else if (push) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef IMEM_FETCH_MISALIGN_CHECK_EN
    logic halted_q, halted_d;

    // Halt and error are the same sticky event, so one flop backs both.
    always_comb begin
        halted_d = halted_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted       = halted_q;
    assign misalign_err = halted_q;
`else
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .wr_entry  (wr_entry),
        .head_entry(head_entry),
        .count     (count)
    );

    assign imem_addr = pc_q;
    assign out_valid = (count != '0);
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, fetch queue entries; legal values 2 and 4.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port fetch_en, input, 1, permits new fetches when high.
REQ-006 SHALL have port imem_addr, output, 32, byte address to instruction_memory.addr.
REQ-007 SHALL have port imem_instr, input, 32, combinational read data from instruction_memory.instr.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-009 SHALL have port redirect_pc, input, 32, redirect target address.
REQ-010 SHALL have port out_valid, output, 1, queue head holds an instruction.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the head.
REQ-012 SHALL have port out_instr, output, 32, head instruction word.
REQ-013 SHALL have port out_pc, output, 32, head instruction address.
REQ-014 SHALL have port misalign_err, output, 1, sticky misaligned-redirect flag (REQ-028).

Function
REQ-015 SHALL drive imem_addr = pc combinationally; pc is an internal 32-bit register.
REQ-016 SHALL define pop = out_valid & out_ready.
REQ-017 SHALL define push = fetch_en & ~redirect_valid & ~halted & (count < QDEPTH | pop).
REQ-018 SHALL, on push, write {pc, imem_instr} at queue tail and set pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL, on pop, retire the head; simultaneous push and pop SHALL leave count unchanged, including when count == QDEPTH.
REQ-020 SHALL drive out_valid = (count != 0); out_instr and out_pc SHALL come from the head entry, registered, with no combinational path from imem_instr.
REQ-021 SHALL, on redirect_valid, set count <= 0, set pc <= redirect_pc, and suppress push that cycle; redirect SHALL take priority over pop and push.
REQ-022 SHALL hold pc and suppress push while fetch_en is low; pops SHALL continue.
REQ-023 SHALL have fetch-to-output latency of 1 cycle: an entry pushed at edge N is visible on out_* after edge N.
REQ-024 SHALL have redirect-to-valid latency of 2 edges: flush at edge N, first target instruction valid after edge N+1.
REQ-025 SHALL present out_* stable while out_valid is high and out_ready is low.

Reset
REQ-026 SHALL, while rst is high, force pc = RESET_PC, count = 0, queue pointers = 0, out_valid = 0, out_instr = 32'h0000_0013 (NOP), out_pc = 0, misalign_err = 0, halted = 0.
REQ-027 SHALL, on rst asserted mid-operation, discard all queued entries immediately; the first push after release SHALL fetch RESET_PC.

Configuration
REQ-028 SHALL, with IMEM_FETCH_MISALIGN_CHECK_EN defined, set misalign_err and halted when redirect_valid is high and redirect_pc[1:0] != 0; the flush still occurs, pushes stop, and both flags clear only on rst.
REQ-029 SHALL, without IMEM_FETCH_MISALIGN_CHECK_EN, load pc with {redirect_pc[31:2], 2'b00}, tie misalign_err to 0, and keep halted at 0.

Structure
REQ-030 SHALL take XLEN = 32, ILEN = 32, NOP_INSTR = 32'h0000_0013 and the fetch-entry struct {pc, instr} from shared package rv32i_pkg.
REQ-031 SHALL implement the queue as sub-module fetch_queue (parameter QDEPTH; push, pop and flush inputs; count output); the PC and redirect logic SHALL stay in imem_fetch_ctrl.

Verification
REQ-032 SHALL cover reset then streaming: rst high for 2 cycles then low, fetch_en = 1, out_ready = 1 -> out_pc = 0, 4, 8 on consecutive cycles, with out_instr matching memory words 0, 1, 2.
REQ-033 SHALL cover backpressure: out_ready = 0 for 5 cycles -> count saturates at QDEPTH, pc stalls at 8 (QDEPTH = 2), head stays out_pc = 0; out_ready = 1 -> in-order drain with no loss or duplicate.
REQ-034 SHALL cover redirect while full: redirect_valid = 1, redirect_pc = 32'h40, out_ready = 1 in the same cycle -> out_valid = 0 next cycle, then out_pc = 32'h40, then 32'h44.
REQ-035 SHALL cover wrap-around: RESET_PC = 32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 SHALL cover misaligned redirect: redirect_pc = 32'h22 -> with macro, misalign_err = 1 and out_valid stays 0 until rst; without macro, out_pc = 32'h20 next.
REQ-037 SHALL cover async reset mid-stream: rst pulsed between clock edges -> out_valid falls without waiting for a clock edge; after release, out_pc = RESET_PC.
